// File: rtl/mole_pkg.sv
// Shared definitions for the whack-a-mole pattern generator and the game core.
// Covers pattern geometry, FSM state encoding, LFSR taps and the fallback position rule.
package mole_pkg;

    localparam int          NUM_SLOTS = 8;
    localparam int          POS_W     = 4;
    localparam int          DATA_W    = NUM_SLOTS * POS_W;
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GEN  = 2'd1,
        EMIT = 2'd2
    } state_t;

    // Deterministic next position used when the random draws keep getting rejected.
    function automatic logic [POS_W-1:0] fallback_pos(input logic [POS_W-1:0] last_val,
                                                      input logic [POS_W-1:0] key_max);
        logic [POS_W-1:0] nxt;
        if (last_val >= key_max) begin
            nxt = {POS_W{1'b0}};
        end else begin
            nxt = last_val + 4'd1;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/mole_pattern_gen_if.sv
// Request/pattern handoff between the pattern generator (master) and the game core (slave).
interface mole_pattern_gen_if;
    import mole_pkg::*;

    logic              game_start;
    logic              req;
    logic [DATA_W-1:0] data_out;
    logic              write_enable;
    logic              busy;
    logic [7:0]        pattern_count;
    logic              req_dropped;

    modport master (
        input  game_start, req,
        output data_out, write_enable, busy, pattern_count, req_dropped
    );

    modport slave (
        output game_start, req,
        input  data_out, write_enable, busy, pattern_count, req_dropped
    );

endinterface

// File: rtl/lfsr16.sv
// Free-running 16-bit Galois LFSR; a zero seed is replaced so the register never locks up.
module lfsr16
    import mole_pkg::*;
#(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic        clk,
    input  logic        reset,
    output logic [15:0] q
);
    localparam logic [15:0] SEED_C = (SEED == 16'h0000) ? 16'h0001 : SEED;

    logic [15:0] q_r;

    // Shift right every cycle, folding the taps in when a one falls out.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q_r <= SEED_C;
        end else if (q_r[0]) begin
            q_r <= (q_r >> 1) ^ LFSR_TAPS;
        end else begin
            q_r <= q_r >> 1;
        end
    end

    assign q = q_r;

endmodule

// File: rtl/mole_pattern_gen.sv
// Mole pattern generator: draws NUM_SLOTS key positions from the LFSR into a build buffer
// and hands each complete pattern to the game core with a one-cycle write strobe.
module mole_pattern_gen
    import mole_pkg::*;
#(
    parameter int          KEY_COUNT = 9,
    parameter logic [15:0] LFSR_SEED = 16'hACE1,
    parameter int          MAX_RETRY = 15
) (
    input  logic               clk,
    input  logic               reset,
    mole_pattern_gen_if.master bus
);
    localparam int                SLOT_W    = $clog2(NUM_SLOTS);
    localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(NUM_SLOTS - 1);
    localparam logic [POS_W-1:0]  KEY_MAX   = POS_W'(KEY_COUNT - 1);
    localparam logic [POS_W:0]    KEY_LIMIT = (POS_W + 1)'(KEY_COUNT);
    localparam logic [7:0]        RETRY_MAX = 8'(MAX_RETRY);

    logic [15:0]       lfsr_q_s;
    logic [POS_W-1:0]  draw_s;
    logic              unused_lfsr_s;
    logic              trig_s;
    logic              accept_s;
    logic              give_up_s;
    logic              take_s;
    logic [POS_W-1:0]  pos_s;

    state_t            state_r;
    logic [SLOT_W-1:0] slot_r;
    logic [7:0]        retry_r;
    logic [POS_W-1:0]  last_val_r;
    logic [DATA_W-1:0] build_r;
    logic              pending_r;
    logic [DATA_W-1:0] data_out_r;
    logic              write_enable_r;
    logic              busy_r;
    logic [7:0]        pattern_count_r;
    logic              req_dropped_r;

    lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (
        .clk   (clk),
        .reset (reset),
        .q     (lfsr_q_s)
    );

    assign draw_s        = lfsr_q_s[POS_W-1:0];
    assign unused_lfsr_s = ^lfsr_q_s[15:POS_W];
    assign trig_s        = bus.game_start | bus.req;

    // A draw is usable when it is a legal key and not a repeat; otherwise fall back once retries run out.
    assign accept_s  = ({1'b0, draw_s} < KEY_LIMIT) && (draw_s != last_val_r);
    assign give_up_s = (retry_r == RETRY_MAX);
    assign take_s    = accept_s | give_up_s;
    assign pos_s     = accept_s ? draw_s : fallback_pos(last_val_r, KEY_MAX);

    // Request FSM, slot/retry bookkeeping, build buffer and registered handoff outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r         <= IDLE;
            slot_r          <= {SLOT_W{1'b0}};
            retry_r         <= 8'd0;
            last_val_r      <= 4'hF;
            build_r         <= {DATA_W{1'b0}};
            pending_r       <= 1'b0;
            data_out_r      <= {DATA_W{1'b0}};
            write_enable_r  <= 1'b0;
            busy_r          <= 1'b0;
            pattern_count_r <= 8'd0;
            req_dropped_r   <= 1'b0;
        end else begin
            write_enable_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (trig_s) begin
                        state_r <= GEN;
                        slot_r  <= {SLOT_W{1'b0}};
                        retry_r <= 8'd0;
                        busy_r  <= 1'b1;
                    end
                end
                GEN: begin
                    if (trig_s) begin
                        if (pending_r) begin
                            req_dropped_r <= 1'b1;
                        end else begin
                            pending_r <= 1'b1;
                        end
                    end
                    if (take_s) begin
                        build_r[slot_r*POS_W +: POS_W] <= pos_s;
                        last_val_r <= pos_s;
                        retry_r    <= 8'd0;
                        if (slot_r == LAST_SLOT) begin
                            state_r <= EMIT;
                        end else begin
                            slot_r <= slot_r + 1'b1;
                        end
                    end else begin
                        retry_r <= retry_r + 8'd1;
                    end
                end
                EMIT: begin
                    data_out_r      <= build_r;
                    write_enable_r  <= 1'b1;
                    pattern_count_r <= pattern_count_r + 8'd1;
                    slot_r          <= {SLOT_W{1'b0}};
                    retry_r         <= 8'd0;
                    // A request arriving now is pended and consumed at once; a second one is lost.
                    if (pending_r | trig_s) begin
                        state_r   <= GEN;
                        busy_r    <= 1'b1;
                        pending_r <= 1'b0;
                        if (pending_r & trig_s) begin
                            req_dropped_r <= 1'b1;
                        end
                    end else begin
                        state_r <= IDLE;
                        busy_r  <= 1'b0;
                    end
                end
                default: begin
                    state_r   <= IDLE;
                    busy_r    <= 1'b0;
                    pending_r <= 1'b0;
                end
            endcase
        end
    end

    assign bus.data_out      = data_out_r;
    assign bus.write_enable  = write_enable_r;
    assign bus.busy          = busy_r;
    assign bus.pattern_count = pattern_count_r;
    assign bus.req_dropped   = req_dropped_r;

endmodule
